// File: rtl/cp_inserter.sv
// Cyclic-prefix inserter: buffers one OFDM symbol in a ping-pong RAM and replays
// its last CP samples followed by the full symbol as one gap-free burst.
module cp_inserter #(
  parameter int DW = 12,
  parameter int N  = 1024,
  parameter int CP = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          isop,
  input  logic          ival,
  input  logic [DW-1:0] in_real_data,
  input  logic [DW-1:0] in_imag_data,
  output logic          osop,
  output logic          oval,
  output logic [DW-1:0] out_real_data,
  output logic [DW-1:0] out_imag_data
);

  localparam int AW = $clog2(N);
  localparam int CW = $clog2(N + CP);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
  localparam logic [CW-1:0] LAST_POS  = CW'(N + CP - 1);
  localparam logic [CW-1:0] CP_LEN    = CW'(CP);
  localparam logic [CW-1:0] CP_OFS    = CW'(N - CP);

  typedef enum logic {RD_IDLE = 1'b0, RD_BURST = 1'b1} rd_state_e;

  logic [2*DW-1:0] mem_q [2*N];
  logic [1:0]      full_q;
  logic            wr_bank_q;
  logic            wr_active_q;
  logic [AW-1:0]   wr_addr_q;
  rd_state_e       rd_state_q;
  logic            rd_bank_q;
  logic [CW-1:0]   rd_pos_q;
  logic            osop_q;
  logic            oval_q;
  logic [DW-1:0]   out_re_q;
  logic [DW-1:0]   out_im_q;

  logic            we_s;
  logic            wr_done_s;
  logic [AW-1:0]   waddr_s;
  logic            issue_s;
  logic            rd_done_s;
  logic [CW-1:0]   pos_s;
  logic [AW-1:0]   idx_s;
  logic [2*DW-1:0] rd_word_s;
  logic [1:0]      set_s;
  logic [1:0]      clr_s;

  // Write qualification: isop only opens a bank that is not still holding a symbol.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = wr_addr_q;
    if (ival) begin
      if (isop) begin
        we_s    = !full_q[wr_bank_q];
        waddr_s = '0;
      end else begin
        we_s    = wr_active_q;
      end
    end else begin
      we_s    = 1'b0;
    end
    wr_done_s = we_s && (waddr_s == LAST_ADDR);
  end

  // Write pointer and bank selection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank_q   <= 1'b0;
      wr_active_q <= 1'b0;
      wr_addr_q   <= '0;
    end else if (ival && isop && full_q[wr_bank_q]) begin
      wr_active_q <= 1'b0;
    end else if (wr_done_s) begin
      wr_active_q <= 1'b0;
      wr_bank_q   <= ~wr_bank_q;
      wr_addr_q   <= '0;
    end else if (we_s) begin
      wr_active_q <= 1'b1;
      wr_addr_q   <= waddr_s + AW'(1);
    end else begin
      wr_active_q <= wr_active_q;
    end
  end

  // Symbol storage, one bank per half of the address space.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_q[{wr_bank_q, waddr_s}] <= {in_real_data, in_imag_data};
    end
  end

  // Burst position to RAM index: first the CP tail, then the symbol from index 0.
  always_comb begin
    if (rd_state_q == RD_BURST) begin
      issue_s = 1'b1;
      pos_s   = rd_pos_q;
    end else begin
      issue_s = full_q[rd_bank_q];
      pos_s   = '0;
    end
    if (pos_s < CP_LEN) begin
      idx_s = AW'(pos_s + CP_OFS);
    end else begin
      idx_s = AW'(pos_s - CP_LEN);
    end
    rd_done_s = issue_s && (pos_s == LAST_POS);
    rd_word_s = mem_q[{rd_bank_q, idx_s}];
  end

  // Readout FSM with registered outputs; a pending bank starts right after the last issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state_q <= RD_IDLE;
      rd_bank_q  <= 1'b0;
      rd_pos_q   <= '0;
      osop_q     <= 1'b0;
      oval_q     <= 1'b0;
      out_re_q   <= '0;
      out_im_q   <= '0;
    end else begin
      osop_q <= issue_s && (rd_state_q == RD_IDLE);
      oval_q <= issue_s;
      if (issue_s) begin
        {out_re_q, out_im_q} <= rd_word_s;
      end else begin
        {out_re_q, out_im_q} <= '0;
      end
      if (rd_done_s) begin
        rd_state_q <= RD_IDLE;
        rd_bank_q  <= ~rd_bank_q;
        rd_pos_q   <= '0;
      end else if (issue_s) begin
        rd_state_q <= RD_BURST;
        rd_pos_q   <= pos_s + CW'(1);
      end else begin
        rd_state_q <= rd_state_q;
      end
    end
  end

  // Bank occupancy events from both sides; they never target the same bank together.
  always_comb begin
    set_s = 2'b00;
    clr_s = 2'b00;
    if (wr_done_s) begin
      set_s[wr_bank_q] = 1'b1;
    end else begin
      set_s = 2'b00;
    end
    if (rd_done_s) begin
      clr_s[rd_bank_q] = 1'b1;
    end else begin
      clr_s = 2'b00;
    end
  end

  // Bank full flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 2'b00;
    end else begin
      full_q <= (full_q | set_s) & ~clr_s;
    end
  end

  assign osop          = osop_q;
  assign oval          = oval_q;
  assign out_real_data = out_re_q;
  assign out_imag_data = out_im_q;

endmodule

// File: tb/tb_cp_inserter.sv
// Self-checking bench for cp_inserter: symbol-level reference model with a
// per-cycle expected-output map, plus a table of fixed single-ramp checkpoints.
module tb_cp_inserter;

  localparam int DW   = 12;
  localparam int N    = 1024;
  localparam int CP   = 32;
  localparam int CAPN = 1200;

  logic          clk;
  logic          rst;
  logic          isop;
  logic          ival;
  logic [DW-1:0] in_real_data;
  logic [DW-1:0] in_imag_data;
  logic          osop;
  logic          oval;
  logic [DW-1:0] out_real_data;
  logic [DW-1:0] out_imag_data;

  cp_inserter #(.DW(DW), .N(N), .CP(CP)) dut (
    .clk           (clk),
    .rst           (rst),
    .isop          (isop),
    .ival          (ival),
    .in_real_data  (in_real_data),
    .in_imag_data  (in_imag_data),
    .osop          (osop),
    .oval          (oval),
    .out_real_data (out_real_data),
    .out_imag_data (out_imag_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state: symbols, bank release cycles, expected beats by cycle.
  logic [2*DW-1:0] m_sym [N];
  bit              m_acc = 1'b0;
  int              m_cnt = 0;
  int              last_end = -100000;
  int              rel_q [$];
  logic [2*DW:0]   exp_q [int];

  logic [2*DW+1:0] cap [CAPN];
  int              ref_cyc = 1 << 30;
  int              osop_cnt = 0;
  int              prev_osop = -1;
  int              period_bad = 0;

  typedef struct {
    int            off;
    logic          sop;
    logic          val;
    logic [DW-1:0] d;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [2*DW+1:0] got, input logic [2*DW+1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h want %h", name, cyc, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    rel_q.delete();
    m_acc    = 1'b0;
    m_cnt    = 0;
    last_end = -100000;
  endtask

  task automatic model_cycle(input int t, input logic s, input logic v,
                             input logic [DW-1:0] re, input logic [DW-1:0] im);
    int start;
    while (rel_q.size() > 0 && t >= rel_q[0]) void'(rel_q.pop_front());
    if (v) begin
      if (s) begin
        m_acc = (rel_q.size() < 2);
        m_cnt = 0;
      end
      if (m_acc) begin
        m_sym[m_cnt] = {re, im};
        m_cnt++;
        if (m_cnt == N) begin
          start = (t + 2 > last_end + 1) ? t + 2 : last_end + 1;
          for (int i = 0; i < N + CP; i++)
            exp_q[start + i] = {1'(i == 0), m_sym[(i < CP) ? (N - CP + i) : (i - CP)]};
          last_end = start + N + CP - 1;
          rel_q.push_back(last_end);
          m_acc = 1'b0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [2*DW+1:0] got;
    logic [2*DW+1:0] want;
    got = {oval, osop, out_real_data, out_imag_data};
    if (exp_q.exists(cyc)) begin
      want = {1'b1, exp_q[cyc]};
      exp_q.delete(cyc);
    end else begin
      want = '0;
    end
    check("stream", got, want);
    if (cyc - ref_cyc >= 0 && cyc - ref_cyc < CAPN) cap[cyc - ref_cyc] = got;
    if (osop) begin
      osop_cnt++;
      if (prev_osop >= 0 && cyc - prev_osop != N + CP) period_bad++;
      prev_osop = cyc;
    end
  endtask

  // One cycle: check this cycle's outputs, present inputs, advance the model.
  task automatic step(input logic s, input logic v, input logic [DW-1:0] re, input logic [DW-1:0] im);
    check_outputs();
    isop = s; ival = v; in_real_data = re; in_imag_data = im;
    if (rst) model_cycle(cyc, s, v, re, im);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'($urandom_range(1)), 1'b0, DW'($urandom), DW'($urandom));
  endtask

  task automatic send_sym(input int nsamp, input int gap_pct, input bit rnd);
    int i = 0;
    while (i < nsamp) begin
      if (i > 0 && gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        step(1'b0, 1'b0, DW'($urandom), DW'($urandom));
      end else begin
        step(1'(i == 0), 1'b1, rnd ? DW'($urandom) : DW'(i), rnd ? DW'($urandom) : DW'(i));
        i++;
      end
    end
  endtask

  initial begin
    int kind;
    tbl[0] = '{1,    1'b0, 1'b0, DW'(0)};
    tbl[1] = '{2,    1'b1, 1'b1, DW'(992)};
    tbl[2] = '{3,    1'b0, 1'b1, DW'(993)};
    tbl[3] = '{33,   1'b0, 1'b1, DW'(1023)};
    tbl[4] = '{34,   1'b0, 1'b1, DW'(0)};
    tbl[5] = '{35,   1'b0, 1'b1, DW'(1)};
    tbl[6] = '{1057, 1'b0, 1'b1, DW'(1023)};
    tbl[7] = '{1058, 1'b0, 1'b0, DW'(0)};

    rst = 1'b0; isop = 1'b0; ival = 1'b0; in_real_data = '0; in_imag_data = '0;
    repeat (3) @(negedge clk);
    check("reset", {oval, osop, out_real_data, out_imag_data}, '0);
    rst = 1'b1;
    idle(20);

    // Single ramp, checked against fixed checkpoints.
    send_sym(N, 0, 1'b0);
    ref_cyc = cyc - 1;
    idle(1100);
    for (int k = 0; k < 8; k++)
      check($sformatf("ramp_off%0d", tbl[k].off), cap[tbl[k].off],
            {tbl[k].val, tbl[k].sop, tbl[k].d, tbl[k].d});
    ref_cyc = 1 << 30;

    // Continuous stream at the sustained period.
    osop_cnt = 0; prev_osop = -1; period_bad = 0;
    for (int s = 0; s < 4; s++) begin
      send_sym(N, 0, 1'b0);
      idle(CP);
    end
    idle(1100);
    check_int("stream_osop_count", osop_cnt, 4);
    check_int("stream_osop_period", period_bad, 0);

    // Gapped ramp input.
    for (int s = 0; s < 2; s++) begin
      send_sym(N, 25, 1'b0);
      idle($urandom_range(40));
    end
    idle(1100);

    // Restart after a partial symbol.
    osop_cnt = 0;
    send_sym(500, 0, 1'b0);
    send_sym(N, 0, 1'b0);
    idle(1100);
    check_int("restart_osop_count", osop_cnt, 1);

    // Overrun: periods shorter than N+CP force dropped symbols.
    for (int s = 0; s < 6; s++) begin
      send_sym(N, 0, 1'b1);
      idle($urandom_range(40));
    end
    idle(2200);

    // Long idle then restart.
    osop_cnt = 0;
    idle(2048);
    check_int("idle_no_osop", osop_cnt, 0);
    send_sym(N, 0, 1'b1);
    idle(1100);
    check_int("after_idle_osop", osop_cnt, 1);

    // Random mix of full, partial, stray-valid and idle traffic.
    for (int it = 0; it < 12; it++) begin
      kind = $urandom_range(3);
      case (kind)
        0: send_sym(N, $urandom_range(30), 1'b1);
        1: send_sym($urandom_range(N - 1, 1), $urandom_range(20), 1'b1);
        2: for (int j = 0; j < int'($urandom_range(50, 1)); j++)
             step(1'b0, 1'b1, DW'($urandom), DW'($urandom));
        default: idle($urandom_range(1200));
      endcase
    end
    idle(2200);

    // Asynchronous reset in the middle of a burst.
    send_sym(N, 0, 1'b1);
    idle(500);
    #2 rst = 1'b0;
    #1 check("async_reset", {oval, osop, out_real_data, out_imag_data}, '0);
    model_reset();
    @(negedge clk);
    cyc++;
    idle(5);
    rst = 1'b1;
    osop_cnt = 0;
    idle(1200);
    check_int("post_reset_quiet", osop_cnt, 0);
    send_sym(N, 10, 1'b0);
    idle(1100);
    check_int("post_reset_burst", osop_cnt, 1);

    check_int("expected_drained", exp_q.num(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cp_inserter.md
Name: cp_inserter

Overview:
- Cyclic-prefix insertion stage for the OFDM transmitter, placed after the IFFT.
- Accepts one complex symbol of N samples framed by isop/ival.
- Emits a continuous N+CP-sample burst: the last CP samples of the symbol, then the full symbol in natural order.
- Downstream, a CP-removal stage consumes osop plus data.

Parameters:
- DW, 12, bit width of each I and Q sample.
- N, 1024, symbol length (FFT size); power of two.
- CP, 32, cyclic-prefix length; 1 <= CP < N.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- isop  in  1  start of symbol; valid only together with ival; marks sample index 0.
- ival  in  1  input sample valid.
- in_real_data  in  DW  input I sample.
- in_imag_data  in  DW  input Q sample.
- osop  out  1  one-cycle pulse with the first output sample (first CP sample).
- oval  out  1  output sample valid; high for exactly N+CP consecutive cycles per symbol.
- out_real_data  out  DW  output I sample.
- out_imag_data  out  DW  output Q sample.

Behaviour:
- Reset (rst=0, async): osop=0, oval=0, data outputs=0, both buffer banks marked empty, write pointer idle. Buffer contents need not be cleared.
- Storage: ping-pong buffer, 2 banks x N complex words. One bank is written while the other is read out.
- Write side:
  - Cycle with ival=1 and isop=1: sample written at address 0 of the current write bank; write address becomes 1.
  - Cycles with ival=1, isop=0 while 0 < addr < N: write at addr, addr+1.
  - ival=0 cycles are gaps: nothing written, address held.
  - ival without a preceding isop (after reset, or after N samples already taken) is ignored.
  - isop mid-symbol restarts at address 0 in the same bank; the partial symbol is discarded.
- Symbol completion: when sample N-1 is written, the bank is marked full and the write bank toggles.
- Read side:
  - Last input sample presented in cycle c -> osop=1, oval=1 and sample[N-CP] on the outputs in cycle c+2 (RAM read plus output register).
  - Then N+CP consecutive oval=1 cycles output indices N-CP..N-1, then 0..N-1.
  - osop is high only in the first of these cycles.
  - After the burst: oval=0, data outputs=0, bank marked empty.
- Back-to-back: if the other bank completes during a readout, it becomes pending. Its readout (with a new osop) starts in the cycle immediately after the current burst's last sample; no gap.
- Overflow: an isop arriving while one bank is being read and the other is full/pending drops that whole symbol (ival ignored until the next isop with a free bank). The buffered data is never corrupted.
- Data passes unmodified; no arithmetic; I and Q are handled identically.
- Sustained throughput: one symbol per N+CP cycles; inputs with period >= N+CP never overflow.

Test Plan:
- Reset: assert rst=0 mid-burst -> outputs 0 immediately (async), oval/osop 0. After release with no input: oval stays 0.
- Single ramp symbol (N=1024, CP=32): I=Q=index 0..1023, isop at index 0, ival for 1024 cycles. -> Two cycles after index 1023: osop pulse. oval high for 1056 cycles, data 992..1023 then 0..1023, then oval=0.
- Continuous stream, period 1056 (1024 valid + 32 idle, repeating ramp): -> every output burst identical to the single-symbol case. osop every 1056 cycles, oval gap-free across bursts.
- Gapped input: ival deasserted for random cycles inside the symbol -> output identical to the gap-free case. Latency measured from the last accepted sample.
- Restart: isop after 500 samples, then a full new ramp of 1024 -> only the second symbol is output (992..1023, 0..1023); the partial symbol is never emitted.
- Input stopped for 2048 cycles and then restarted with isop -> no spurious oval during the idle span. First new burst is correct.
